// File: rtl/brick_scan_pkg.sv
// Shared constants, FSM state encoding and the brick index -> pixel mapping
// used by the brick scanner and its neighbours.
package brick_scan_pkg;

  localparam int BRICKNUM  = 128;
  localparam int BRICKDRAW = 16;

  localparam logic [2:0] COL_ERASE = 3'b000;
  localparam logic [2:0] COL_HP1   = 3'b010;
  localparam logic [2:0] COL_HP2   = 3'b110;
  localparam logic [2:0] COL_HP3   = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_WAIT = 3'd2,
    S_PREP = 3'd3,
    S_DRAW = 3'd4,
    S_NEXT = 3'd5,
    S_DONE = 3'd6
  } state_t;

  // Brick grid: 8 columns of 40x16 pixel bricks, first row at y=32.
  localparam logic [9:0] BRICK_W_PX = 10'd40;
  localparam logic [9:0] BRICK_H_PX = 10'd16;
  localparam logic [9:0] GRID_Y0    = 10'd32;

  // Returns {x, y} of the top-left pixel of brick idx.
  function automatic logic [19:0] address_xy(input logic [9:0] idx);
    logic [9:0] col;
    logic [9:0] row;
    col = {7'd0, idx[2:0]};
    row = {3'd0, idx[9:3]};
    return {col * BRICK_W_PX, GRID_Y0 + row * BRICK_H_PX};
  endfunction

endpackage

// File: rtl/brick_scan_if.sv
// Port bundle between the brick scanner, the brick RAM read port and the
// VGA draw arbiter.
interface brick_scan_if;
  // Handshake: start is a level sampled only while the scanner is idle (no
  // ready, no queuing); scan_draw and done are one-cycle strobes with no
  // backpressure; rd_data must be valid one cycle after rd_address.
  logic       start;
  logic [9:0] rd_address;
  logic [1:0] rd_data;
  logic [9:0] x_out;
  logic [9:0] y_out;
  logic [2:0] colour;
  logic       scan_draw;
  logic       writeEn;
  logic       busy;
  logic       done;
  logic [9:0] remaining_health;
  logic       cleared;

  modport master (
    input  start, rd_data,
    output rd_address, x_out, y_out, colour, scan_draw, writeEn,
           busy, done, remaining_health, cleared
  );

  modport slave (
    output start, rd_data,
    input  rd_address, x_out, y_out, colour, scan_draw, writeEn,
           busy, done, remaining_health, cleared
  );
endinterface

// File: rtl/brick_colour.sv
// Combinational brick health -> draw colour lookup.
module brick_colour
  import brick_scan_pkg::*;
(
  input  logic [1:0] health,
  output logic [2:0] colour
);

  always_comb begin
    colour = COL_ERASE;
    case (health)
      2'd1:    colour = COL_HP1;
      2'd2:    colour = COL_HP2;
      2'd3:    colour = COL_HP3;
      default: colour = COL_ERASE;
    endcase
  end

endmodule

// File: rtl/brick_scan.sv
// Walks the brick RAM, issues one draw request per brick and totals live health.
// Build option SKIP_EMPTY_EN: bricks with health 0 are not drawn.
module brick_scan
  import brick_scan_pkg::*;
#(
  parameter int BRICK_NUM  = BRICKNUM,
  parameter int DRAW_DELAY = BRICKDRAW
) (
  input  logic   clk,
  input  logic   reset,
  brick_scan_if.master bus,
  output state_t state_dbg
);

  localparam int               CNT_W      = (DRAW_DELAY < 1) ? 1 : $clog2(DRAW_DELAY + 1);
  localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(DRAW_DELAY);
  localparam logic [9:0]       INDEX_LAST = 10'(BRICK_NUM - 1);

  state_t           state, next_state;
  logic [9:0]       index;
  logic [9:0]       acc;
  logic [9:0]       rem_r;
  logic             clr_r;
  logic [CNT_W-1:0] draw_cnt;
  logic [9:0]       x_r, y_r;
  logic [2:0]       col_r;
  logic [2:0]       col_live;
  logic [19:0]      xy_live;
  logic             skip_brick;
  logic             draw_now;

  brick_colour u_colour (
    .health (bus.rd_data),
    .colour (col_live)
  );

  assign xy_live = address_xy(index);

`ifdef SKIP_EMPTY_EN
  assign skip_brick = (bus.rd_data == 2'd0);
`else
  assign skip_brick = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (bus.start) next_state = S_READ;
      S_READ: next_state = S_WAIT;
      S_WAIT: next_state = S_PREP;
      S_PREP: next_state = skip_brick ? S_NEXT : S_DRAW;
      S_DRAW: if (draw_cnt == DRAW_LAST) next_state = S_NEXT;
      S_NEXT: next_state = (index == INDEX_LAST) ? S_DONE : S_READ;
      S_DONE: next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // While the draw strobe is high the live lookup is shown so the arbiter
  // can latch x/y/colour on the strobe itself; afterwards the registers hold it.
  always_comb begin
    draw_now             = (state == S_PREP) && !skip_brick;
    bus.scan_draw        = draw_now;
    bus.writeEn          = (state == S_DRAW);
    bus.busy             = (state != S_IDLE);
    bus.done             = (state == S_DONE);
    bus.rd_address       = index;
    bus.x_out            = draw_now ? xy_live[19:10] : x_r;
    bus.y_out            = draw_now ? xy_live[9:0]   : y_r;
    bus.colour           = draw_now ? col_live       : col_r;
    bus.remaining_health = rem_r;
    bus.cleared          = clr_r;
    state_dbg            = state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index    <= '0;
      acc      <= '0;
      rem_r    <= '0;
      clr_r    <= 1'b0;
      draw_cnt <= '0;
      x_r      <= '0;
      y_r      <= '0;
      col_r    <= '0;
    end else begin
      case (state)
        S_PREP: begin
          acc <= acc + 10'(bus.rd_data);
          if (draw_now) begin
            x_r   <= xy_live[19:10];
            y_r   <= xy_live[9:0];
            col_r <= col_live;
          end
        end
        S_DRAW: begin
          if (draw_cnt == DRAW_LAST) draw_cnt <= '0;
          else                       draw_cnt <= draw_cnt + 1'b1;
        end
        S_NEXT: begin
          if (index != INDEX_LAST) index <= index + 10'd1;
        end
        S_DONE: begin
          rem_r <= acc;
          clr_r <= (acc == 10'd0);
          acc   <= '0;
          index <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
